// File: rtl/present_pkg.sv
// Shared definitions for the PRESENT-80 cores.
//   BLOCK_W / KEY_W / ROUNDS : fixed datapath widths and round count
//   fsm_e                    : decrypt-core control states
//   SBOX_INV_TABLE           : inverse S-box, nibble n at bits [4n+3:4n]
//   inv_p()                  : inverse bit permutation layer
package present_pkg;

    localparam int unsigned BLOCK_W = 64;
    localparam int unsigned KEY_W   = 80;
    localparam int unsigned ROUNDS  = 31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEXP = 2'd1,
        DEC  = 2'd2,
        DONE = 2'd3
    } fsm_e;

    // Entries listed from input F (MSB) down to input 0 (LSB).
    localparam logic [63:0] SBOX_INV_TABLE = 64'hA970_364B_D21C_8FE5;

    // Undo the forward layer: bit j lands at (4*j) mod 63, bit 63 fixed.
    function automatic logic [BLOCK_W-1:0] inv_p(input logic [BLOCK_W-1:0] x);
        logic [BLOCK_W-1:0] y;
        y = '0;
        for (int unsigned j = 0; j < BLOCK_W - 1; j++) begin
            y[(4 * j) % (BLOCK_W - 1)] = x[j];
        end
        y[BLOCK_W-1] = x[BLOCK_W-1];
        return y;
    endfunction

endpackage

// File: rtl/sbox.sv
// Forward PRESENT S-box (4-bit, combinational).
//   x_i : input nibble
//   y_o : substituted nibble
module sbox (
    input  logic [3:0] x_i,
    output logic [3:0] y_o
);

    always_comb begin
        y_o = '0;
        case (x_i)
            4'h0: y_o = 4'hC;
            4'h1: y_o = 4'h5;
            4'h2: y_o = 4'h6;
            4'h3: y_o = 4'hB;
            4'h4: y_o = 4'h9;
            4'h5: y_o = 4'h0;
            4'h6: y_o = 4'hA;
            4'h7: y_o = 4'hD;
            4'h8: y_o = 4'h3;
            4'h9: y_o = 4'hE;
            4'hA: y_o = 4'hF;
            4'hB: y_o = 4'h8;
            4'hC: y_o = 4'h4;
            4'hD: y_o = 4'h7;
            4'hE: y_o = 4'h1;
            4'hF: y_o = 4'h2;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/sbox_inv.sv
// Inverse PRESENT S-box (4-bit, combinational), table lookup.
//   x_i : input nibble
//   y_o : inverse-substituted nibble
module sbox_inv
    import present_pkg::*;
(
    input  logic [3:0] x_i,
    output logic [3:0] y_o
);

    assign y_o = SBOX_INV_TABLE[{x_i, 2'b00} +: 4];

endmodule

// File: rtl/present_decrypt_core.sv
// Iterative PRESENT-80 decryption, one round per clock.
// A job first walks the key schedule forward to K32 (31 cycles), then runs
// 31 inverse rounds while stepping the schedule backwards.
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset
//   start_i : job request, sampled only while ready_o is high
//   data_i  : ciphertext, sampled with an accepted start
//   key_i   : 80-bit user key, sampled with an accepted start
//   ready_o : high while idle
//   valid_o : one-cycle pulse when data_o carries a new plaintext
//   data_o  : plaintext, held until the next result
module present_decrypt_core
    import present_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [BLOCK_W-1:0] data_i,
    input  logic [KEY_W-1:0]   key_i,
    output logic               ready_o,
    output logic               valid_o,
    output logic [BLOCK_W-1:0] data_o
);

    fsm_e               fsm_q;
    logic [BLOCK_W-1:0] state_q;
    logic [BLOCK_W-1:0] data_q;
    logic [KEY_W-1:0]   key_q;
    logic [4:0]         cnt_q;
    logic               valid_q;

    // Forward schedule step: rotl 61, S on top nibble, counter into [19:15].
    logic [KEY_W-1:0] kexp_rot;
    logic [3:0]       kexp_nib;
    logic [KEY_W-1:0] kexp_key;

    assign kexp_rot = {key_q[18:0], key_q[79:19]};

    sbox u_sbox_kexp (
        .x_i (kexp_rot[79:76]),
        .y_o (kexp_nib)
    );

    assign kexp_key = {kexp_nib, kexp_rot[75:20], kexp_rot[19:15] ^ cnt_q, kexp_rot[14:0]};

    // Inverse schedule step: undo the counter, then Sinv, then rotr 61.
    logic [KEY_W-1:0] dk_mix;
    logic [3:0]       dk_nib;
    logic [KEY_W-1:0] dk_sub;
    logic [KEY_W-1:0] dec_key;

    assign dk_mix = {key_q[79:20], key_q[19:15] ^ cnt_q, key_q[14:0]};

    sbox_inv u_sbox_inv_key (
        .x_i (dk_mix[79:76]),
        .y_o (dk_nib)
    );

    assign dk_sub  = {dk_nib, dk_mix[75:0]};
    assign dec_key = {dk_sub[60:0], dk_sub[79:61]};

    // Inverse round datapath: invP, then 16 parallel inverse S-boxes, then key add.
    logic [BLOCK_W-1:0] perm;
    logic [BLOCK_W-1:0] sub;
    logic [BLOCK_W-1:0] dec_state;

    assign perm = inv_p(state_q);

    for (genvar n = 0; n < 16; n++) begin : g_sinv
        sbox_inv u_sbox_inv (
            .x_i (perm[4*n +: 4]),
            .y_o (sub[4*n +: 4])
        );
    end

    assign dec_state = sub ^ dec_key[79:16];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            data_q  <= '0;
            key_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (start_i) begin
                        key_q   <= key_i;
                        state_q <= data_i;
                        cnt_q   <= 5'd1;
                        fsm_q   <= KEXP;
                    end
                end
                KEXP: begin
                    key_q <= kexp_key;
                    if (cnt_q == 5'(ROUNDS)) begin
                        // K32 is produced on this edge; apply it as the first
                        // whitening step so DEC starts directly on round 31.
                        state_q <= state_q ^ kexp_key[79:16];
                        fsm_q   <= DEC;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                DEC: begin
                    key_q   <= dec_key;
                    state_q <= dec_state;
                    if (cnt_q == 5'd1) begin
                        data_q  <= dec_state;
                        valid_q <= 1'b1;
                        fsm_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                DONE: begin
                    valid_q <= 1'b0;
                    fsm_q   <= IDLE;
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign ready_o = (fsm_q == IDLE);
    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: doc/present_decrypt_core.md
# present_decrypt_core

Iterative PRESENT-80 decryption core, one round per clock. It is the inverse of the encryption datapath. It accepts a 64-bit ciphertext and an 80-bit user key, expands the key forward to the last round key, then runs 31 inverse rounds with an on-the-fly inverse key schedule. Its output is the 64-bit plaintext. It sits beside the encryption core and reuses the forward `sbox` for key expansion.

## Interface
- No parameters. Widths are fixed: block 64, key 80, rounds 31.
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `start_i` in 1: request. Sampled only when `ready_o`=1.
- `data_i` in 64: ciphertext. Sampled with an accepted `start_i`.
- `key_i` in 80: user key K1. Sampled with an accepted `start_i`.
- `ready_o` out 1: high in IDLE only.
- `valid_o` out 1: one-cycle pulse when `data_o` holds a new plaintext.
- `data_o` out 64: plaintext. Held until the next accepted start.

## Operation
- FSM states: IDLE → KEXP → DEC → DONE → IDLE.
- Registers: `state_q[63:0]`, `key_q[79:0]`, `cnt_q[4:0]`, FSM state.
- IDLE
  - `start_i`=1: load `key_q`←`key_i`, `state_q`←`data_i`, `cnt_q`←1, go to KEXP.
  - Otherwise: hold.
- KEXP (forward schedule, cnt 1..31), each cycle:
  - k←k rotl 61
  - k[79:76]←S(k[79:76])
  - k[19:15]^=cnt
  - cnt++
- KEXP exit, on cnt=31:
  - `key_q` now holds K32.
  - Same edge: `state_q`←`state_q` ^ next_key[79:16].
  - `cnt_q` stays 31. Go to DEC.
- DEC (round r=`cnt_q`, 31 down to 1), each cycle:
  - next_key = inverse step of `key_q`: k[19:15]^=r; k[79:76]←Sinv(k[79:76]); k←k rotr 61. The result is K_r.
  - `state_q`←Sinv16(invP(`state_q`)) ^ next_key[79:16].
  - `key_q`←next_key. cnt--.
  - On r=1: go to DONE.
- invP: input bit j moves to position (4·j) mod 63 for j<63. Bit 63 stays fixed.
- Sinv (per nibble): 0→5, 1→E, 2→F, 3→8, 4→C, 5→1, 6→2, 7→D, 8→B, 9→4, A→6, B→3, C→0, D→7, E→9, F→A.
- DONE: `valid_o`=1, `data_o`=`state_q`, go to IDLE next edge.
- `data_o` is a registered copy of `state_q`. It updates only on entry to DONE.
- `start_i` is ignored in KEXP, DEC and DONE. No queuing.

## Timing
- Reset values: `ready_o`=1, `valid_o`=0, `data_o`=0, FSM=IDLE, all internal registers 0.
- `rst_i` asserted at any time, including mid-KEXP or mid-DEC: immediate return to reset values. The in-flight job is discarded and no `valid_o` is produced.
- Latency, with start accepted on edge E0:
  - KEXP runs on edges E0+1..E0+31.
  - DEC runs on edges E0+32..E0+62.
  - `valid_o` is high for exactly the cycle after E0+62.
  - `ready_o` returns high after edge E0+63.
  - Throughput: one block per 64 cycles.
- `ready_o` is a decode of FSM=IDLE (glitch-free, registered state).
- `start_i` held high continuously: a new job is accepted on every IDLE cycle, giving back-to-back 64-cycle jobs.
- `cnt_q` never wraps. Its range is 1..31. The 5-bit counter XOR aligns to k[19:15].

## Structure
- Shared package `present_pkg`:
  - `BLOCK_W`=64, `KEY_W`=80, `ROUNDS`=31.
  - FSM enum {IDLE, KEXP, DEC, DONE}.
  - Inverse S-box constant table.
  - invP as a function.
- Sub-module `sbox_inv`: 4-bit combinational inverse S-box.
  - 16 instances on the state.
  - 1 instance on the key nibble in DEC.
- The existing forward `sbox` is instantiated once for the key nibble in KEXP.

## Test plan
- Key 0, ciphertext 5579C1387B228445 → `data_o`=0000000000000000, `valid_o` pulse at E0+63.
- Key FFFF…FF (80 bits), ciphertext E72C46C0F5945049 → 0000000000000000.
- Key 0, ciphertext A112FFC72F68417B → FFFFFFFFFFFFFFFF.
- Key all-ones, ciphertext 3333DCD3213210D2 → FFFFFFFFFFFFFFFF. Also verify `ready_o`=0 from E0+1 to E0+63.
- Pulse `rst_i` at DEC round 10 → all outputs at reset values, no `valid_o`. A following start with vector 1 decrypts correctly.
- `start_i` toggled with new data while busy → ignored, result matches the first job. With `start_i` held high, two jobs complete 64 cycles apart.
